// File: rtl/led_display_scheduler_pkg.sv
// Shared definitions for the seven-segment display scheduler: page codes,
// converter states, BCD limits and small combinational helpers.
package led_display_scheduler_pkg;

  localparam logic [2:0] PAGE_CPU    = 3'b000;
  localparam logic [2:0] PAGE_TOTAL  = 3'b001;
  localparam logic [2:0] PAGE_UNCOND = 3'b011;
  localparam logic [2:0] PAGE_COND   = 3'b111;
  localparam logic [2:0] PAGE_RAM    = 3'b010;

  localparam int unsigned NUM_SRC    = 3;
  localparam int unsigned BCD_DIGITS = 8;
  localparam logic [31:0] BCD_MAX    = 32'd99_999_999;
  localparam logic [31:0] BCD_SAT    = 32'h9999_9999;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_e;

  // Auto-rotation order; anything unexpected falls back to the CPU page.
  function automatic logic [2:0] next_page(input logic [2:0] cur);
    case (cur)
      PAGE_CPU:    next_page = PAGE_TOTAL;
      PAGE_TOTAL:  next_page = PAGE_UNCOND;
      PAGE_UNCOND: next_page = PAGE_COND;
      PAGE_COND:   next_page = PAGE_RAM;
      default:     next_page = PAGE_CPU;
    endcase
  endfunction

  // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
  function automatic logic [31:0] bcd_adjust(input logic [31:0] v);
    logic [31:0] r;
    r = v;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (v[4*k +: 4] >= 4'd5) r[4*k +: 4] = v[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/led_display_scheduler_bcd_seq_conv.sv
// Iterative binary-to-BCD converter (double dabble), one bit per clock:
// IDLE -> SHIFT (32 clk) -> DONE (1 clk). Inputs above 99_999_999 saturate.
module led_display_scheduler_bcd_seq_conv
  import led_display_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] din_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] dout_o
);

  conv_state_e state_q, state_d;
  logic [31:0] bin_q;
  logic [31:0] bcd_q;
  logic [4:0]  cnt_q;
  logic        sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CONV_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CONV_IDLE:  if (start_i) state_d = CONV_SHIFT;
      CONV_SHIFT: if (cnt_q == 5'd31) state_d = CONV_DONE;
      CONV_DONE:  state_d = CONV_IDLE;
      default:    state_d = CONV_IDLE;
    endcase
  end

  // Operand is latched at start so source changes mid-conversion are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (state_q == CONV_IDLE && start_i) begin
      bin_q <= din_i;
      bcd_q <= '0;
      cnt_q <= '0;
      sat_q <= (din_i > BCD_MAX);
    end else if (state_q == CONV_SHIFT) begin
      {bcd_q, bin_q} <= {bcd_adjust(bcd_q), bin_q} << 1;
      cnt_q          <= cnt_q + 5'd1;
    end
  end

  always_comb begin
    busy_o = (state_q != CONV_IDLE);
    done_o = (state_q == CONV_DONE);
    dout_o = sat_q ? BCD_SAT : bcd_q;
  end

endmodule

// File: rtl/led_display_scheduler.sv
// Display path sequencer: digit scan prescaler, page FSM (manual/auto),
// round-robin BCD conversion of three counters, and the registered output mux.
module led_display_scheduler
  import led_display_scheduler_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 100_000,
  parameter int unsigned PAGE_FRAMES = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        led_cpu_enable,
  input  logic [31:0] led_data_in,
  input  logic [2:0]  manual_op,
  input  logic        auto_mode,
  input  logic [31:0] total_cycles,
  input  logic [31:0] uncondi_branch_num,
  input  logic [31:0] condi_branch_num,
  input  logic [31:0] ram_display_data_out,
  output logic [2:0]  display_op,
  output logic [31:0] disp_data,
  output logic        disp_valid,
  output logic [2:0]  scan_idx,
  output logic        scan_tick
);

  localparam int unsigned PS_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FR_W = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;

  logic [PS_W-1:0] ps_q, ps_d;
  logic [2:0]      scan_q;
  logic            tick;
  logic            frame_end;

  logic [2:0]      op_q, op_d;
  logic [FR_W-1:0] frame_q, frame_d;
  logic            auto_q;

  logic [31:0]     cpu_q;
  logic            cpu_valid_q;
  logic [31:0]     cache_q [NUM_SRC];
  logic [NUM_SRC-1:0] valid_q;
  logic [1:0]      rr_q, src_q;

  logic            conv_start, conv_busy, conv_done;
  logic [31:0]     conv_din, conv_dout;

  logic [31:0]     disp_data_q, disp_data_d;
  logic            disp_valid_q, disp_valid_d;

  assign tick      = (ps_q == PS_W'(SCAN_DIV - 1));
  assign ps_d      = tick ? '0 : ps_q + 1'b1;
  assign frame_end = tick && (scan_q == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q   <= '0;
      scan_q <= '0;
    end else begin
      ps_q <= ps_d;
      if (tick) scan_q <= scan_q + 3'd1;
    end
  end

  // Page FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= PAGE_CPU;
      frame_q <= '0;
      auto_q  <= 1'b0;
    end else begin
      op_q    <= op_d;
      frame_q <= frame_d;
      auto_q  <= auto_mode;
    end
  end

  // Page FSM: next state; a rising auto_mode restarts rotation at the CPU page
  always_comb begin
    op_d    = op_q;
    frame_d = frame_q;
    if (!auto_mode) begin
      op_d    = manual_op;
      frame_d = '0;
    end else if (!auto_q) begin
      op_d    = PAGE_CPU;
      frame_d = '0;
    end else if (frame_end) begin
      if (frame_q == FR_W'(PAGE_FRAMES - 1)) begin
        op_d    = next_page(op_q);
        frame_d = '0;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  // Page FSM: output selection, registered one cycle behind display_op
  always_comb begin
    disp_data_d  = '0;
    disp_valid_d = 1'b0;
    case (op_q)
      PAGE_CPU:    begin disp_data_d = cpu_q;                disp_valid_d = cpu_valid_q; end
      PAGE_RAM:    begin disp_data_d = ram_display_data_out; disp_valid_d = 1'b1;        end
      PAGE_TOTAL:  begin disp_data_d = cache_q[0];           disp_valid_d = valid_q[0];  end
      PAGE_UNCOND: begin disp_data_d = cache_q[1];           disp_valid_d = valid_q[1];  end
      PAGE_COND:   begin disp_data_d = cache_q[2];           disp_valid_d = valid_q[2];  end
      default:     begin disp_data_d = '0;                   disp_valid_d = 1'b0;        end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_q       <= '0;
      cpu_valid_q <= 1'b0;
    end else if (led_cpu_enable) begin
      cpu_q       <= led_data_in;
      cpu_valid_q <= 1'b1;
    end
  end

  // Converter is granted whenever it sits in IDLE; src_q remembers who owns it.
  assign conv_start = !conv_busy;

  always_comb begin
    case (rr_q)
      2'd0:    conv_din = total_cycles;
      2'd1:    conv_din = uncondi_branch_num;
      default: conv_din = condi_branch_num;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q    <= '0;
      src_q   <= '0;
      valid_q <= '0;
      for (int s = 0; s < NUM_SRC; s++) cache_q[s] <= '0;
    end else begin
      if (conv_start) begin
        src_q <= rr_q;
        rr_q  <= (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
      end
      for (int s = 0; s < NUM_SRC; s++) begin
        if (conv_done && src_q == 2'(s)) begin
          cache_q[s] <= conv_dout;
          valid_q[s] <= 1'b1;
        end
      end
    end
  end

  led_display_scheduler_bcd_seq_conv u_bcd_seq_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (conv_start),
    .din_i   (conv_din),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .dout_o  (conv_dout)
  );

  assign display_op = op_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign scan_idx   = scan_q;
  assign scan_tick  = tick;

endmodule

// File: tb/tb_led_display_scheduler.sv
// Directed self-checking bench for led_display_scheduler (SCAN_DIV=4, PAGE_FRAMES=2).
module tb_led_display_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        led_cpu_enable;
  logic [31:0] led_data_in;
  logic [2:0]  manual_op;
  logic        auto_mode;
  logic [31:0] total_cycles;
  logic [31:0] uncondi_branch_num;
  logic [31:0] condi_branch_num;
  logic [31:0] ram_display_data_out;
  logic [2:0]  display_op;
  logic [31:0] disp_data;
  logic        disp_valid;
  logic [2:0]  scan_idx;
  logic        scan_tick;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  led_display_scheduler #(.SCAN_DIV(4), .PAGE_FRAMES(2)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .led_cpu_enable       (led_cpu_enable),
    .led_data_in          (led_data_in),
    .manual_op            (manual_op),
    .auto_mode            (auto_mode),
    .total_cycles         (total_cycles),
    .uncondi_branch_num   (uncondi_branch_num),
    .condi_branch_num     (condi_branch_num),
    .ram_display_data_out (ram_display_data_out),
    .display_op           (display_op),
    .disp_data            (disp_data),
    .disp_valid           (disp_valid),
    .scan_idx             (scan_idx),
    .scan_tick            (scan_tick)
  );

  task automatic test_reset();
    rst_n                = 1'b0;
    led_cpu_enable       = 1'b0;
    led_data_in          = 32'h0;
    manual_op            = 3'b001;
    auto_mode            = 1'b0;
    total_cycles         = 32'd12_345_678;
    uncondi_branch_num   = 32'd42;
    condi_branch_num     = 32'd100_000_000;
    ram_display_data_out = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (display_op !== 3'b000 || disp_data !== 32'h0 || disp_valid !== 1'b0 ||
          scan_idx !== 3'd0 || scan_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: op=%b data=%h valid=%b idx=%0d tick=%b, required all zero",
                 display_op, disp_data, disp_valid, scan_idx, scan_tick);
      end
      n_tests++;
      if (dut.conv_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_done: done=%b, required 0", dut.conv_done);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_manual_bcd();
    repeat (110) @(negedge clk);
    n_tests++;
    if (display_op !== 3'b001 || disp_data !== 32'h1234_5678 || disp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL total_bcd: op=%b data=%h valid=%b, required 001 12345678 1",
               display_op, disp_data, disp_valid);
    end
    manual_op = 3'b111;
    repeat (2) @(negedge clk);
    n_tests++;
    if (disp_data !== 32'h9999_9999 || disp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL cond_saturate: data=%h valid=%b, required 99999999 1", disp_data, disp_valid);
    end
    manual_op = 3'b011;
    @(negedge clk);
    n_tests++;
    if (display_op !== 3'b011 || disp_data !== 32'h9999_9999) begin
      n_fail++;
      $display("FAIL manual_latency: op=%b data=%h, required 011 99999999", display_op, disp_data);
    end
    @(negedge clk);
    n_tests++;
    if (disp_data !== 32'h0000_0042 || disp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL uncond_bcd: data=%h valid=%b, required 00000042 1", disp_data, disp_valid);
    end
    manual_op = 3'b101;
    repeat (2) @(negedge clk);
    n_tests++;
    if (display_op !== 3'b101 || disp_data !== 32'h0 || disp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_page: op=%b data=%h valid=%b, required 101 0 0",
               display_op, disp_data, disp_valid);
    end
  endtask

  task automatic test_scan();
    int   cyc;
    logic [2:0] idx0;
    logic [2:0] exp_idx;
    cyc = 0;
    while (scan_tick !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (scan_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL scan_tick_seen: tick=%b after %0d clk, required 1", scan_tick, cyc);
    end
    idx0 = scan_idx;
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      n_tests++;
      if (scan_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL scan_tick_low: tick=%b, required 0", scan_tick);
      end
      repeat (3) @(negedge clk);
      exp_idx = idx0 + 3'(t + 1);
      n_tests++;
      if (scan_tick !== 1'b1 || scan_idx !== exp_idx) begin
        n_fail++;
        $display("FAIL scan_step: tick=%b idx=%0d, required 1 %0d", scan_tick, scan_idx, exp_idx);
      end
    end
  endtask

  task automatic test_cpu_capture();
    manual_op            = 3'b010;
    ram_display_data_out = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    n_tests++;
    if (disp_data !== 32'hCAFE_F00D || disp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ram_page: data=%h valid=%b, required cafef00d 1", disp_data, disp_valid);
    end
    led_cpu_enable = 1'b1;
    led_data_in    = 32'hDEAD_BEEF;
    @(negedge clk);
    led_cpu_enable = 1'b0;
    led_data_in    = 32'h0;
    manual_op      = 3'b000;
    @(negedge clk);
    n_tests++;
    if (display_op !== 3'b000 || disp_data !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL cpu_latency: op=%b data=%h, required 000 cafef00d", display_op, disp_data);
    end
    @(negedge clk);
    n_tests++;
    if (disp_data !== 32'hDEAD_BEEF || disp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL cpu_capture: data=%h valid=%b, required deadbeef 1", disp_data, disp_valid);
    end
  endtask

  task automatic test_reset_midconv();
    int cyc;
    @(negedge clk);
    rst_n        = 1'b0;
    manual_op    = 3'b001;
    auto_mode    = 1'b0;
    total_cycles = 32'd11_111_111;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_tests++;
    if (dut.conv_start !== 1'b1) begin
      n_fail++;
      $display("FAIL first_start: start=%b, required 1", dut.conv_start);
    end
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (dut.valid_q !== 3'b000 || disp_valid !== 1'b0 || display_op !== 3'b000) begin
      n_fail++;
      $display("FAIL midconv_reset: valid=%b disp_valid=%b op=%b, required 000 0 000",
               dut.valid_q, disp_valid, display_op);
    end
    total_cycles = 32'd87_654_321;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (dut.conv_done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin
        n_tests++;
        if (disp_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL stale_valid: valid=%b, required 0", disp_valid);
        end
      end
    end
    n_tests++;
    if (cyc != 33) begin
      n_fail++;
      $display("FAIL done_latency: done after %0d clk, required 33", cyc);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (disp_data !== 32'h8765_4321 || disp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fresh_cache: data=%h valid=%b, required 87654321 1", disp_data, disp_valid);
    end
  endtask

  task automatic test_auto();
    logic [2:0] exp_seq [5];
    logic [2:0] prev;
    int cyc;
    exp_seq[0] = 3'b001;
    exp_seq[1] = 3'b011;
    exp_seq[2] = 3'b111;
    exp_seq[3] = 3'b010;
    exp_seq[4] = 3'b000;
    @(negedge clk);
    rst_n     = 1'b0;
    auto_mode = 1'b1;
    manual_op = 3'b101;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev  = display_op;
    for (int s = 0; s < 5; s++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (display_op === prev && cyc < 200);
      n_tests++;
      if (display_op !== exp_seq[s] || cyc != 64 || scan_idx !== 3'd0) begin
        n_fail++;
        $display("FAIL auto_step%0d: op=%b after %0d clk idx=%0d, required %b after 64 idx=0",
                 s, display_op, cyc, scan_idx, exp_seq[s]);
      end
      prev = display_op;
    end
    auto_mode = 1'b0;
    manual_op = 3'b011;
    @(negedge clk);
    n_tests++;
    if (display_op !== 3'b011) begin
      n_fail++;
      $display("FAIL leave_auto: op=%b, required 011", display_op);
    end
  endtask

  initial begin
    test_reset();
    test_manual_bcd();
    test_scan();
    test_cpu_capture();
    test_reset_midconv();
    test_auto();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
